debounce_scheduler: RTL and testbench

Debounces up to NUM_BTNS active-low pushbuttons using a single shared wait timer instead of one timer per button. Each channel runs a small edge-tracking FSM. Channels that see a press queue for the timer, and a round-robin arbiter grants it to one channel at a time. When the wait expires, the owning button is sampled once and a one-cycle press pulse is emitted if it is still held. The block sits between raw board buttons and any counter or LED logic that must see exactly one event per physical press.

---
 rtl/debounce_scheduler.sv | 136 +++++++++++++
 tb/tb_debounce_scheduler.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/debounce_scheduler.sv
// debounce_scheduler: debounces NUM_BTNS active-low pushbuttons with one
// shared wait timer. Channels that see a press queue for the timer; a
// round-robin arbiter hands it to one channel at a time, and on expiry the
// owner is sampled once and a single-cycle press pulse is emitted if held.
module debounce_scheduler #(
  parameter int NUM_BTNS    = 4,
  parameter int WAIT_CYCLES = 480000,
  parameter int CNT_W       = 20,
  localparam int OWN_W      = $clog2(NUM_BTNS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_BTNS-1:0] btn_n,
  output logic [NUM_BTNS-1:0] press,
  output logic                busy,
  output logic [OWN_W-1:0]    owner
);

  localparam logic [1:0] CH_HIGH = 2'd0;
  localparam logic [1:0] CH_ARM  = 2'd1;
  localparam logic [1:0] CH_PEND = 2'd2;
  localparam logic [1:0] CH_WAIT = 2'd3;

  localparam logic T_IDLE = 1'b0;
  localparam logic T_RUN  = 1'b1;

  logic [NUM_BTNS-1:0]      sync1_q, sync2_q;
  logic [NUM_BTNS-1:0]      pressed;
  logic [NUM_BTNS-1:0][1:0] chState_q, chState_d;
  logic                     timerState_q, timerState_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [OWN_W-1:0]         owner_q, owner_d;
  logic [OWN_W-1:0]         rrPtr_q, rrPtr_d;
  logic [NUM_BTNS-1:0]      press_q, press_d;
  logic [NUM_BTNS-1:0]      pendVec;
  logic                     grantValid;
  logic [OWN_W-1:0]         grantIdx;
  logic [OWN_W:0]           candSum;
  logic                     grantFire;
  logic                     expire;

  assign pressed = ~sync2_q;
  assign press   = press_q;
  assign busy    = (timerState_q == T_RUN);
  assign owner   = owner_q;

  assign expire    = (timerState_q == T_RUN) && (cnt_q == CNT_W'(WAIT_CYCLES - 1));
  assign grantFire = (timerState_q == T_IDLE) && grantValid;

  // Two-flop synchronizer; resets to the released (high) level so no channel sees a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= btn_n;
      sync2_q <= sync1_q;
    end
  end

  // Round-robin search: first pending channel at or after rrPtr, wrapping around.
  always_comb begin
    grantValid = 1'b0;
    grantIdx   = '0;
    candSum    = '0;
    for (int i = 0; i < NUM_BTNS; i++) begin
      pendVec[i] = (chState_q[i] == CH_PEND);
    end
    for (int k = 0; k < NUM_BTNS; k++) begin
      candSum = {1'b0, rrPtr_q} + (OWN_W + 1)'(k);
      if (candSum >= (OWN_W + 1)'(NUM_BTNS)) begin
        candSum = candSum - (OWN_W + 1)'(NUM_BTNS);
      end
      if (!grantValid && pendVec[candSum[OWN_W-1:0]]) begin
        grantValid = 1'b1;
        grantIdx   = candSum[OWN_W-1:0];
      end
    end
  end

  // Per-channel edge tracking: wait for a release, then a press, then queue for the timer.
  always_comb begin
    chState_d = chState_q;
    for (int i = 0; i < NUM_BTNS; i++) begin
      case (chState_q[i])
        CH_HIGH: if (!pressed[i]) chState_d[i] = CH_ARM;
        CH_ARM:  if (pressed[i])  chState_d[i] = CH_PEND;
        CH_PEND: if (grantFire && (grantIdx == OWN_W'(i))) chState_d[i] = CH_WAIT;
        CH_WAIT: if (expire) chState_d[i] = CH_HIGH;
        default: chState_d[i] = CH_HIGH;
      endcase
    end
  end

  // Shared timer: grants only from idle, so a new grant always lands one edge after an expiry.
  always_comb begin
    timerState_d = timerState_q;
    cnt_d        = cnt_q;
    owner_d      = owner_q;
    rrPtr_d      = rrPtr_q;
    press_d      = '0;
    if (timerState_q == T_IDLE) begin
      if (grantValid) begin
        timerState_d = T_RUN;
        cnt_d        = '0;
        owner_d      = grantIdx;
        rrPtr_d      = (grantIdx == OWN_W'(NUM_BTNS - 1)) ? '0 : grantIdx + OWN_W'(1);
      end
    end else if (expire) begin
      timerState_d     = T_IDLE;
      press_d[owner_q] = pressed[owner_q];
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State registers; reset discards any in-flight wait without a pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chState_q    <= '0;
      timerState_q <= T_IDLE;
      cnt_q        <= '0;
      owner_q      <= '0;
      rrPtr_q      <= '0;
      press_q      <= '0;
    end else begin
      chState_q    <= chState_d;
      timerState_q <= timerState_d;
      cnt_q        <= cnt_d;
      owner_q      <= owner_d;
      rrPtr_q      <= rrPtr_d;
      press_q      <= press_d;
    end
  end

endmodule

// File: tb/tb_debounce_scheduler.sv
// Directed testbench for debounce_scheduler with NUM_BTNS=4, WAIT_CYCLES=8.
// Edges are counted from the posedge at which a stimulus is first applied.
module tb_debounce_scheduler;

  logic       clk;
  logic       rst;
  logic [3:0] btnN;
  logic [3:0] press;
  logic       busy;
  logic [1:0] owner;

  int checks;
  int failures;
  int pulseCnt [4];
  int multiHot;
  int pulseOrder [$];

  debounce_scheduler #(
    .NUM_BTNS(4),
    .WAIT_CYCLES(8),
    .CNT_W(20)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_n(btnN),
    .press(press),
    .busy(busy),
    .owner(owner)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every pulse away from the active edge and flag any multi-hot cycle.
  always @(negedge clk) begin
    if ($countones(press) > 1) multiHot++;
    for (int i = 0; i < 4; i++) begin
      if (press[i]) begin
        pulseCnt[i]++;
        pulseOrder.push_back(i);
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic doReset();
    @(posedge clk);
    #1 rst = 1'b1;
    btnN = 4'hF;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  // Clean press on button 2 with the full edge-by-edge timing checked.
  task automatic applyStimulus(input string tag);
    int base;
    base = pulseCnt[2];
    @(posedge clk);
    #1 btnN[2] = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("%s_press_e%0d", tag, k), {28'd0, press}, (k == 12) ? 32'h4 : 32'h0);
      checkOutput($sformatf("%s_busy_e%0d", tag, k), {31'd0, busy}, (k >= 4 && k < 12) ? 32'h1 : 32'h0);
      if (k == 4) checkOutput({tag, "_owner"}, {30'd0, owner}, 32'd2);
    end
    btnN[2] = 1'b1;
    repeat (5) @(posedge clk);
    checkOutput({tag, "_count"}, pulseCnt[2] - base, 32'd1);
  endtask

  initial begin
    int base;
    checks   = 0;
    failures = 0;
    multiHot = 0;
    for (int i = 0; i < 4; i++) pulseCnt[i] = 0;
    rst  = 1'b1;
    btnN = 4'hF;
    #12;
    checkOutput("reset_press", {28'd0, press}, 32'h0);
    checkOutput("reset_busy", {31'd0, busy}, 32'h0);
    checkOutput("reset_owner", {30'd0, owner}, 32'h0);
    doReset();

    // Single clean press
    applyStimulus("clean");

    // Bounce then steady hold: exactly one pulse
    doReset();
    base = pulseCnt[0];
    @(posedge clk);
    for (int k = 0; k < 6; k++) begin
      #1 btnN[0] = k[0];
      @(posedge clk);
    end
    #1 btnN[0] = 1'b0;
    repeat (40) @(posedge clk);
    checkOutput("bounce_count", pulseCnt[0] - base, 32'd1);
    #1 btnN[0] = 1'b1;
    repeat (10) @(posedge clk);

    // Release before expiry: no pulse
    base = pulseCnt[0];
    #1 btnN[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1 btnN[0] = 1'b1;
    repeat (4) @(posedge clk);
    #1 checkOutput("early_release_busy", {31'd0, busy}, 32'h1);
    repeat (20) @(posedge clk);
    checkOutput("early_release_count", pulseCnt[0] - base, 32'd0);

    // Contention between channels 0 and 1
    doReset();
    @(posedge clk);
    #1 btnN[1:0] = 2'b00;
    for (int k = 1; k <= 22; k++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("contend_press_e%0d", k), {28'd0, press},
                  (k == 12) ? 32'h1 : ((k == 21) ? 32'h2 : 32'h0));
      checkOutput($sformatf("contend_busy_e%0d", k), {31'd0, busy},
                  ((k >= 4 && k <= 11) || (k >= 13 && k <= 20)) ? 32'h1 : 32'h0);
      if (k == 13) checkOutput("contend_owner", {30'd0, owner}, 32'd1);
    end
    btnN = 4'hF;
    repeat (5) @(posedge clk);

    // Round robin: first from pointer 0, then from pointer 1
    doReset();
    pulseOrder.delete();
    #1 btnN = 4'h0;
    repeat (60) @(posedge clk);
    checkOutput("rr1_len", pulseOrder.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < pulseOrder.size()) checkOutput($sformatf("rr1_order%0d", i), pulseOrder[i], i);
    end
    #1 btnN = 4'hF;
    repeat (5) @(posedge clk);
    #1 btnN[0] = 1'b0;
    repeat (20) @(posedge clk);
    #1 btnN = 4'hF;
    repeat (5) @(posedge clk);
    pulseOrder.delete();
    #1 btnN = 4'h0;
    repeat (60) @(posedge clk);
    checkOutput("rr2_len", pulseOrder.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < pulseOrder.size()) checkOutput($sformatf("rr2_order%0d", i), pulseOrder[i], (i + 1) % 4);
    end
    #1 btnN = 4'hF;
    repeat (5) @(posedge clk);

    // Long hold gives one pulse; release and re-press gives a second
    doReset();
    base = pulseCnt[3];
    #1 btnN[3] = 1'b0;
    repeat (100) @(posedge clk);
    checkOutput("hold_count1", pulseCnt[3] - base, 32'd1);
    #1 btnN[3] = 1'b1;
    repeat (5) @(posedge clk);
    #1 btnN[3] = 1'b0;
    repeat (20) @(posedge clk);
    checkOutput("hold_count2", pulseCnt[3] - base, 32'd2);
    #1 btnN[3] = 1'b1;
    repeat (5) @(posedge clk);

    // Reset in the middle of a wait
    doReset();
    base = pulseCnt[1];
    @(posedge clk);
    #1 btnN[1] = 1'b0;
    repeat (4) @(posedge clk);
    #1 checkOutput("midrst_owner_before", {30'd0, owner}, 32'd1);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checkOutput("midrst_busy", {31'd0, busy}, 32'h0);
    checkOutput("midrst_owner", {30'd0, owner}, 32'h0);
    checkOutput("midrst_press", {28'd0, press}, 32'h0);
    btnN = 4'hF;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (20) @(posedge clk);
    checkOutput("midrst_no_pulse", pulseCnt[1] - base, 32'd0);
    applyStimulus("afterrst");

    checkOutput("onehot", multiHot, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
